// File: rtl/wb_write_port.sv
// Register-file write port: merges ALU results and load responses into an in-order queue
// and retires one write per cycle. Define WB_PENDING_EN to add the pending-write scoreboard output.
module wb_write_port #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        alu_valid,
    input  logic [3:0]  alu_dest,
    input  logic [31:0] alu_result,
    output logic        alu_ready,
    input  logic        mem_valid,
    input  logic [3:0]  mem_dest,
    input  logic [31:0] mem_data,
    output logic        mem_ready,
    output logic        write_back_en,
    output logic [3:0]  dest_wb,
    output logic [31:0] result_wb
`ifdef WB_PENDING_EN
    ,
    output logic [14:0] pending
`endif
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);
    localparam logic [CW-1:0] DEPTH_C    = CW'(DEPTH);
    localparam logic [CW-1:0] DEPTH_M1_C = CW'(DEPTH - 1);
    localparam logic [PW-1:0] LAST_PTR   = PW'(DEPTH - 1);
    localparam logic [3:0]    PC_IDX     = 4'd15;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        logic [PW-1:0] r;
        if (p == LAST_PTR) begin
            r = '0;
        end else begin
            r = p + PW'(1);
        end
        return r;
    endfunction

    logic [CW-1:0] count_q, count_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [3:0]    q_dest_q [DEPTH];
    logic [3:0]    q_dest_d [DEPTH];
    logic [31:0]   q_data_q [DEPTH];
    logic [31:0]   q_data_d [DEPTH];
    logic          wb_en_q, wb_en_d;
    logic [3:0]    dest_wb_q, dest_wb_d;
    logic [31:0]   result_wb_q, result_wb_d;

    logic          mem_ready_s, alu_ready_s;
    logic          mem_keep_s, alu_keep_s;
    logic          have_first_s, have_second_s;
    logic [3:0]    first_dest_s;
    logic [31:0]   first_data_s;
    logic          pop_s, push_a_s, push_b_s;
    logic [3:0]    push_a_dest_s;
    logic [31:0]   push_a_data_s;
    logic [PW-1:0] wp_s;

    // Readies look only at the registered count; ALU keeps one slot free for a same-cycle load.
    always_comb begin
        mem_ready_s = (count_q < DEPTH_C);
        alu_ready_s = (count_q < DEPTH_M1_C);
    end

    assign mem_ready = mem_ready_s;
    assign alu_ready = alu_ready_s;

    // Accepted items bound for r15 (PC) complete the handshake but are dropped here.
    always_comb begin
        mem_keep_s    = mem_valid & mem_ready_s & (mem_dest != PC_IDX);
        alu_keep_s    = alu_valid & alu_ready_s & (alu_dest != PC_IDX);
        have_first_s  = mem_keep_s | alu_keep_s;
        have_second_s = mem_keep_s & alu_keep_s;
        if (mem_keep_s) begin
            first_dest_s = mem_dest;
            first_data_s = mem_data;
        end else begin
            first_dest_s = alu_dest;
            first_data_s = alu_result;
        end
    end

    // Retire selection: queue head first, else bypass the first accepted item; the rest is enqueued.
    always_comb begin
        wb_en_d       = 1'b0;
        dest_wb_d     = dest_wb_q;
        result_wb_d   = result_wb_q;
        rd_ptr_d      = rd_ptr_q;
        pop_s         = 1'b0;
        push_a_s      = 1'b0;
        push_b_s      = 1'b0;
        push_a_dest_s = first_dest_s;
        push_a_data_s = first_data_s;
        if (count_q != '0) begin
            wb_en_d     = 1'b1;
            dest_wb_d   = q_dest_q[rd_ptr_q];
            result_wb_d = q_data_q[rd_ptr_q];
            rd_ptr_d    = ptr_inc(rd_ptr_q);
            pop_s       = 1'b1;
            push_a_s    = have_first_s;
            push_b_s    = have_second_s;
        end else if (have_first_s) begin
            wb_en_d       = 1'b1;
            dest_wb_d     = first_dest_s;
            result_wb_d   = first_data_s;
            push_a_s      = have_second_s;
            push_a_dest_s = alu_dest;
            push_a_data_s = alu_result;
        end else begin
            wb_en_d = 1'b0;
        end
    end

    // Queue storage update; a second push always carries the ALU result behind the load.
    always_comb begin
        q_dest_d = q_dest_q;
        q_data_d = q_data_q;
        wp_s     = wr_ptr_q;
        if (push_a_s) begin
            q_dest_d[wp_s] = push_a_dest_s;
            q_data_d[wp_s] = push_a_data_s;
            wp_s           = ptr_inc(wp_s);
        end else begin
            wp_s = wr_ptr_q;
        end
        if (push_b_s) begin
            q_dest_d[wp_s] = alu_dest;
            q_data_d[wp_s] = alu_result;
            wp_s           = ptr_inc(wp_s);
        end else begin
            wp_s = wp_s;
        end
        wr_ptr_d = wp_s;
        count_d  = count_q + CW'(push_a_s) + CW'(push_b_s) - CW'(pop_s);
    end

    // State registers; reset drops every queued and presented write.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q     <= '0;
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            wb_en_q     <= 1'b0;
            dest_wb_q   <= 4'd0;
            result_wb_q <= 32'd0;
            for (int i = 0; i < DEPTH; i++) begin
                q_dest_q[i] <= 4'd0;
                q_data_q[i] <= 32'd0;
            end
        end else begin
            count_q     <= count_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            wb_en_q     <= wb_en_d;
            dest_wb_q   <= dest_wb_d;
            result_wb_q <= result_wb_d;
            q_dest_q    <= q_dest_d;
            q_data_q    <= q_data_d;
        end
    end

    assign write_back_en = wb_en_q;
    assign dest_wb       = dest_wb_q;
    assign result_wb     = result_wb_q;

`ifdef WB_PENDING_EN
    function automatic logic [PW-1:0] ptr_add(input logic [PW-1:0] p, input int off);
        int s;
        s = int'(p) + off;
        if (s >= DEPTH) begin
            s = s - DEPTH;
        end else begin
            s = s;
        end
        return PW'(s);
    endfunction

    logic [15:0] pend_s;

    // Live entries are the count_q slots starting at the read pointer, plus the presented write.
    always_comb begin
        pend_s = 16'd0;
        for (int i = 0; i < DEPTH; i++) begin
            if (CW'(i) < count_q) begin
                pend_s[q_dest_q[ptr_add(rd_ptr_q, i)]] = 1'b1;
            end else begin
                pend_s = pend_s;
            end
        end
        if (wb_en_q) begin
            pend_s[dest_wb_q] = 1'b1;
        end else begin
            pend_s = pend_s;
        end
    end

    assign pending = pend_s[14:0];
`endif

endmodule

// File: tb/tb_wb_write_port.sv
// Scoreboard bench for wb_write_port: accepted writes are logged in order and compared at retire.
module tb_wb_write_port;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        alu_valid = 1'b0;
    logic [3:0]  alu_dest = 4'd0;
    logic [31:0] alu_result = 32'd0;
    logic        alu_ready;
    logic        mem_valid = 1'b0;
    logic [3:0]  mem_dest = 4'd0;
    logic [31:0] mem_data = 32'd0;
    logic        mem_ready;
    logic        write_back_en;
    logic [3:0]  dest_wb;
    logic [31:0] result_wb;
`ifdef WB_PENDING_EN
    logic [14:0] pending;
`endif

    wb_write_port #(.DEPTH(DEPTH)) dut (
        .clk           (clk),
        .rst           (rst),
        .alu_valid     (alu_valid),
        .alu_dest      (alu_dest),
        .alu_result    (alu_result),
        .alu_ready     (alu_ready),
        .mem_valid     (mem_valid),
        .mem_dest      (mem_dest),
        .mem_data      (mem_data),
        .mem_ready     (mem_ready),
        .write_back_en (write_back_en),
        .dest_wb       (dest_wb),
        .result_wb     (result_wb)
`ifdef WB_PENDING_EN
        ,
        .pending       (pending)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]  dest;
        logic [31:0] data;
    } item_t;

    item_t sb[$];
    int    n_total = 0;
    int    n_bad = 0;
    int    alu_stall_seen = 0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    // Called on a falling edge: compares the presented write and readies against the log.
    task automatic monitor();
        item_t       it;
        logic [15:0] pexp;
        pexp = 16'd0;
        if (sb.size() == 0) begin
            check_eq("wb_idle", 32'(write_back_en), 32'd0);
        end else begin
            check_eq("wb_en", 32'(write_back_en), 32'd1);
            if (write_back_en) begin
                it = sb.pop_front();
                check_eq("dest_wb", 32'(dest_wb), 32'(it.dest));
                check_eq("result_wb", result_wb, it.data);
                pexp[it.dest] = 1'b1;
            end
        end
        check_eq("mem_ready", 32'(mem_ready), 32'(sb.size() < DEPTH));
        check_eq("alu_ready", 32'(alu_ready), 32'(sb.size() < DEPTH - 1));
        if (!alu_ready) alu_stall_seen++;
`ifdef WB_PENDING_EN
        foreach (sb[k]) pexp[sb[k].dest] = 1'b1;
        check_eq("pending", 32'(pending), 32'(pexp[14:0]));
`endif
    endtask

    // One clock: check outputs, drive inputs for the next rising edge, log what will be accepted.
    task automatic step(input logic av, input logic [3:0] ad, input logic [31:0] ar,
                        input logic mv, input logic [3:0] md, input logic [31:0] mdat);
        @(negedge clk);
        monitor();
        alu_valid  = av;
        alu_dest   = ad;
        alu_result = ar;
        mem_valid  = mv;
        mem_dest   = md;
        mem_data   = mdat;
        #1;
        if (mv && mem_ready && md != 4'd15) sb.push_back('{dest: md, data: mdat});
        if (av && alu_ready && ad != 4'd15) sb.push_back('{dest: ad, data: ar});
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check_eq("rst_wb_en", 32'(write_back_en), 32'd0);
        check_eq("rst_dest", 32'(dest_wb), 32'd0);
        check_eq("rst_result", result_wb, 32'd0);
        rst = 1'b1;
        idle(2);

        // single ALU write to r3
        step(1'b1, 4'd3, 32'h0000_00A5, 1'b0, 4'd0, 32'd0);
        idle(3);

        // load and ALU in the same cycle: load retires first
        step(1'b1, 4'd2, 32'h22, 1'b1, 4'd1, 32'h11);
        idle(3);

        // PC destination is accepted and discarded
        step(1'b1, 4'd15, 32'hDEAD, 1'b0, 4'd0, 32'd0);
        check_eq("pc_handshake", 32'(alu_ready), 32'd1);
        idle(3);

        // back-to-back writes to r5
        step(1'b0, 4'd0, 32'd0, 1'b1, 4'd5, 32'h1);
        step(1'b1, 4'd5, 32'h2, 1'b0, 4'd0, 32'd0);
        idle(3);

        // both streams every cycle, random registers including r15
        for (int i = 0; i < 24; i++) begin
            step(1'b1, 4'($urandom_range(0, 15)), $urandom,
                 1'b1, 4'($urandom_range(0, 15)), $urandom);
        end
        idle(8);
        check_eq("alu_throttled", 32'(alu_stall_seen > 0), 32'd1);

        // reset with three entries queued
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 4'(i + 6), 32'h100 + 32'(i), 1'b1, 4'(i + 9), 32'h200 + 32'(i));
        end
        @(negedge clk);
        monitor();
        alu_valid = 1'b0;
        mem_valid = 1'b0;
        #2;
        rst = 1'b0;
        sb.delete();
        #1;
        check_eq("midrst_wb_en", 32'(write_back_en), 32'd0);
        check_eq("midrst_mem_ready", 32'(mem_ready), 32'd1);
        check_eq("midrst_alu_ready", 32'(alu_ready), 32'd1);
`ifdef WB_PENDING_EN
        check_eq("midrst_pending", 32'(pending), 32'd0);
`endif
        repeat (2) @(negedge clk);
        rst = 1'b1;
        idle(3);
        step(1'b1, 4'd4, 32'h44, 1'b0, 4'd0, 32'd0);
        idle(3);

        check_eq("sb_drained", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
